// File: rtl/ooo_queue_pkg.sv
// Shared defaults, width helpers and entry type for out-of-order queues.
package ooo_queue_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int WIDTH_DEF = 32;

  typedef struct packed {
    logic                 valid;
    logic [WIDTH_DEF-1:0] data;
  } entry_t;

  function automatic int cnt_w(input int d);
    return $clog2(d + 1);
  endfunction

  function automatic int idx_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/compact_net.sv
// Combinational order-preserving compaction of surviving entries to low indices.
module compact_net
  import ooo_queue_pkg::*;
#(
  parameter int N = DEPTH_DEF,
  parameter int W = WIDTH_DEF
) (
  input  logic [N-1:0]             valid_i,
  input  logic [N-1:0][W-1:0]      data_i,
  output logic [N-1:0][W-1:0]      data_o,
  output logic [cnt_w(N)-1:0]      cnt_o
);

  localparam int CW = cnt_w(N);

  int pos;

  // Each survivor lands at the number of survivors below it.
  always_comb begin
    data_o = '0;
    pos    = 0;
    for (int i = 0; i < N; i++) begin
      if (valid_i[i]) begin
        data_o[pos] = data_i[i];
        pos = pos + 1;
      end
    end
    cnt_o = pos[CW-1:0];
  end

endmodule

// File: rtl/collapsing_queue.sv
// Collapsing issue queue: arbitrary removal, compaction, in-order enqueue.
// Optional oldest-ready select port enabled by COLLAPSING_QUEUE_SELECT_EN.
module collapsing_queue
  import ooo_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enq_valid,
  input  logic [WIDTH-1:0]            enq_data,
  output logic                        enq_ready,
  input  logic [DEPTH-1:0]            clr_mask,
  input  logic                        flush,
`ifdef COLLAPSING_QUEUE_SELECT_EN
  input  logic [DEPTH-1:0]            rdy_mask,
  input  logic                        sel_take,
  output logic                        sel_valid,
  output logic [idx_w(DEPTH)-1:0]     sel_idx,
  output logic [WIDTH-1:0]            sel_data,
`endif
  output logic [DEPTH-1:0][WIDTH-1:0] ent_data,
  output logic [DEPTH-1:0]            ent_valid,
  output logic [cnt_w(DEPTH)-1:0]     count,
  output logic                        full,
  output logic                        empty
);

  localparam int CW = cnt_w(DEPTH);
  localparam int IW = idx_w(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d, cmp_data;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [CW-1:0]               count_q, count_d, s;
  logic [DEPTH-1:0]            clr_eff, surv;
  logic                        full_w, enq_fire;

  assign full_w   = (count_q == CW'(DEPTH));
  assign enq_fire = enq_valid && !full_w;

`ifdef COLLAPSING_QUEUE_SELECT_EN
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_data  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && rdy_mask[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(i);
        sel_data  = data_q[i];
      end
    end
  end

  always_comb begin
    clr_eff = clr_mask;
    if (sel_take && sel_valid) clr_eff[sel_idx] = 1'b1;
  end
`else
  assign clr_eff = clr_mask;
`endif

  assign surv = valid_q & ~clr_eff;

  compact_net #(.N(DEPTH), .W(WIDTH)) u_compact (
    .valid_i (surv),
    .data_i  (data_q),
    .data_o  (cmp_data),
    .cnt_o   (s)
  );

  always_comb begin
    data_d  = cmp_data;
    valid_d = '0;
    count_d = s;
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = (i < int'(s));
      if (enq_fire && i == int'(s)) begin
        data_d[i]  = enq_data;
        valid_d[i] = 1'b1;
      end
    end
    if (enq_fire) count_d = s + CW'(1);
    // Flush keeps stale payloads; only valid bits matter.
    if (flush) begin
      data_d  = data_q;
      valid_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign ent_data  = data_q;
  assign ent_valid = valid_q;
  assign count     = count_q;
  assign full      = full_w;
  assign empty     = (count_q == '0);
  assign enq_ready = !full_w;

endmodule

// File: tb/tb_collapsing_queue.sv
// Directed bench for collapsing_queue with a queue-based reference model.
module tb_collapsing_queue;

  localparam int D = 16;
  localparam int W = 32;

  logic              clk = 0;
  logic              rst = 1;
  logic              enq_valid = 0;
  logic [W-1:0]      enq_data = '0;
  logic              enq_ready;
  logic [D-1:0]      clr_mask = '0;
  logic              flush = 0;
  logic [D-1:0][W-1:0] ent_data;
  logic [D-1:0]      ent_valid;
  logic [4:0]        count;
  logic              full, empty;
`ifdef COLLAPSING_QUEUE_SELECT_EN
  logic [D-1:0]      rdy_mask = '0;
  logic              sel_take = 0;
  logic              sel_valid;
  logic [3:0]        sel_idx;
  logic [W-1:0]      sel_data;
`endif

  collapsing_queue #(.DEPTH(D), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .enq_valid (enq_valid),
    .enq_data  (enq_data),
    .enq_ready (enq_ready),
    .clr_mask  (clr_mask),
    .flush     (flush),
`ifdef COLLAPSING_QUEUE_SELECT_EN
    .rdy_mask  (rdy_mask),
    .sel_take  (sel_take),
    .sel_valid (sel_valid),
    .sel_idx   (sel_idx),
    .sel_data  (sel_data),
`endif
    .ent_data  (ent_data),
    .ent_valid (ent_valid),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;
  logic [W-1:0] mq[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic model_apply(input logic ev, input logic [W-1:0] d,
                             input logic [D-1:0] cm, input logic fl);
    logic [W-1:0] nq[$];
    bit ready;
    ready = (mq.size() < D);
    if (fl) begin
      mq.delete();
      return;
    end
    foreach (mq[i]) if (!cm[i]) nq.push_back(mq[i]);
    if (ev && ready) nq.push_back(d);
    mq = nq;
  endtask

  task automatic check_all();
    logic [D-1:0] vm;
    vm = '0;
    for (int i = 0; i < mq.size(); i++) vm[i] = 1'b1;
    chk("count", 64'(count), 64'(mq.size()));
    chk("full", 64'(full), 64'(mq.size() == D));
    chk("empty", 64'(empty), 64'(mq.size() == 0));
    chk("enq_ready", 64'(enq_ready), 64'(mq.size() != D));
    chk("ent_valid", 64'(ent_valid), 64'(vm));
    for (int i = 0; i < mq.size(); i++)
      chk($sformatf("ent_data[%0d]", i), 64'(ent_data[i]), 64'(mq[i]));
  endtask

  always @(negedge clk) if (chk_en) check_all();

  task automatic step(input logic ev, input logic [W-1:0] d,
                      input logic [D-1:0] cm, input logic fl);
    @(negedge clk);
    enq_valid = ev;
    enq_data  = d;
    clr_mask  = cm;
    flush     = fl;
    @(posedge clk);
    model_apply(ev, d, cm, fl);
    #1;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_valid"}, 64'(ent_valid), 64'(0));
    chk({tag, "_data"}, 64'(ent_data), 64'(0));
    chk({tag, "_count"}, 64'(count), 64'(0));
    chk({tag, "_empty"}, 64'(empty), 64'(1));
    chk({tag, "_full"}, 64'(full), 64'(0));
    chk({tag, "_ready"}, 64'(enq_ready), 64'(1));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset_vals("rst");
    @(negedge clk);
    rst = 0;
    chk_en = 1;

    // Fill with 1..16
    for (int i = 1; i <= 16; i++) step(1, W'(i), '0, 0);
    for (int i = 0; i < 16; i++)
      chk("fill_data", 64'(ent_data[i]), 64'(i + 1));
    chk("fill_count", 64'(count), 64'd16);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_ready", 64'(enq_ready), 64'd0);

    step(1, 32'h77, '0, 0);
    chk("drop_full", 64'(ent_data[15]), 64'd16);

    step(0, '0, 16'hAAAA, 0);
    for (int i = 0; i < 8; i++)
      chk("odd_data", 64'(ent_data[i]), 64'(2 * i + 1));
    chk("odd_count", 64'(count), 64'd8);

    step(0, '0, 16'hFFFF, 0);
    chk("clr_all", 64'(empty), 64'd1);

    step(1, 32'hA, '0, 0);
    step(1, 32'hB, '0, 0);
    step(1, 32'hC, '0, 0);
    step(1, 32'hD, 16'h0002, 0);
    chk("acd_0", 64'(ent_data[0]), 64'hA);
    chk("acd_1", 64'(ent_data[1]), 64'hC);
    chk("acd_2", 64'(ent_data[2]), 64'hD);
    chk("acd_cnt", 64'(count), 64'd3);

    // Mixed removal with enqueue, and clears aimed at invalid slots
    step(1, 32'h100, 16'h0005, 0);
    step(1, 32'h101, 16'hFFF0, 0);
    for (int i = 0; i < 13; i++) step(1, 32'h200 + W'(i), '0, 0);
    step(1, 32'h99, 16'h0001, 0);
    chk("rm_full_cnt", 64'(count), 64'd15);
    chk("rm_full_rdy", 64'(enq_ready), 64'd1);

    step(0, '0, '0, 1);
    for (int i = 0; i < 5; i++) step(1, 32'h300 + W'(i), '0, 0);
    step(1, 32'h55, 16'h001F, 1);
    chk("flush_cnt", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);

    // Asynchronous reset partway through a fill
    step(1, 32'h400, '0, 0);
    step(1, 32'h401, '0, 0);
    @(negedge clk);
    enq_data = 32'h402;
    @(posedge clk);
    model_apply(1, 32'h402, '0, 0);
    #2 rst = 1;
    mq.delete();
    #1 reset_vals("midrst");
    @(posedge clk);
    #1 reset_vals("midrst_hold");
    @(negedge clk);
    rst = 0;
    enq_valid = 0;
    step(1, 32'h500, '0, 0);
    chk("post_rst", 64'(ent_data[0]), 64'h500);

`ifdef COLLAPSING_QUEUE_SELECT_EN
    step(0, '0, '0, 1);
    for (int i = 1; i <= 4; i++) step(1, W'(i), '0, 0);
    @(negedge clk);
    enq_valid = 0;
    rdy_mask  = 16'h000C;
    sel_take  = 1;
    #1;
    chk("sel_valid", 64'(sel_valid), 64'd1);
    chk("sel_idx", 64'(sel_idx), 64'd2);
    chk("sel_data", 64'(sel_data), 64'd3);
    @(posedge clk);
    model_apply(0, '0, 16'h0004, 0);
    #1;
    chk("sel_rm1", 64'(ent_data[2]), 64'd4);
    chk("sel_cnt", 64'(count), 64'd3);
    @(negedge clk);
    rdy_mask = '0;
    sel_take = 0;
    #1;
    chk("sel_none_v", 64'(sel_valid), 64'd0);
    chk("sel_none_d", 64'(sel_data), 64'd0);
`endif

    step(0, '0, '0, 0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
